adc_frame_reader: RTL



---
 rtl/adc_frame_reader_pkg.sv | 20 ++
 rtl/adc_frame_reader_if.sv | 30 +++
 rtl/adc_frame_reader_sync_fifo_sa.sv | 56 +++++
 rtl/adc_frame_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/adc_frame_reader_pkg.sv
// Shared constants, FSM state type and sample conversion for the ADC frame reader.
// Offset-binary to two's complement is a pure MSB inversion.
package adc_rd_pkg;

  localparam int FRAME_LEN = 2176;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 14;

  typedef enum logic [1:0] {
    IDLE,
    RD_EVEN,
    RD_ODD,
    DRAIN
  } rd_state_e;

  function automatic logic [DATA_W-1:0] ob_to_tc(input logic [DATA_W-1:0] raw);
    return {~raw[DATA_W-1], raw[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_frame_reader_if.sv
// Dual-bank RAM read ports plus the outgoing sample stream (valid/ready).
// master = frame reader, slave = RAMs and downstream consumer.
interface adc_frame_reader_if;

  logic                         RdEnEven;
  logic [adc_rd_pkg::ADDR_W-1:0] RdAddrEven;
  logic [adc_rd_pkg::DATA_W-1:0] RdDataEven;
  logic                         RdEnOdd;
  logic [adc_rd_pkg::ADDR_W-1:0] RdAddrOdd;
  logic [adc_rd_pkg::DATA_W-1:0] RdDataOdd;
  logic [adc_rd_pkg::DATA_W-1:0] OutData;
  logic                         OutValid;
  logic                         OutReady;
  logic                         OutLast;

  modport master (
    output RdEnEven, RdAddrEven, RdEnOdd, RdAddrOdd,
    input  RdDataEven, RdDataOdd,
    output OutData, OutValid, OutLast,
    input  OutReady
  );

  modport slave (
    input  RdEnEven, RdAddrEven, RdEnOdd, RdAddrOdd,
    output RdDataEven, RdDataOdd,
    input  OutData, OutValid, OutLast,
    output OutReady
  );

endinterface

// File: rtl/adc_frame_reader_sync_fifo_sa.sv
// Show-ahead synchronous FIFO: head visible on dat_o one cycle after push.
// Push while full is accepted only alongside a pop; pop while empty is ignored.
module sync_fifo_sa #(
  parameter  int WIDTH = 15,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/adc_frame_reader.sv
// Drains one frame from even/odd RAM banks in interleaved order as two's complement samples.
// First sample 3 cycles after FrameReady; reads pause whenever FIFO plus in-flight read would exceed depth.
module adc_frame_reader
  import adc_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               ClockFromADC,
  input  logic               Reset,
  input  logic               FrameReady,
  output logic               Busy,
  output logic               Overrun,
  adc_frame_reader_if.master rd
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_even_q, addr_even_d;
  logic [ADDR_W-1:0] addr_odd_q, addr_odd_d;
  logic              inflight_q, sel_odd_q, last_q;
  logic              rd_even, rd_odd, last_issue;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W:0]   fifo_head, fifo_wdat;
  logic [CNT_W:0]    occupancy;
  logic              room;

  // A read issued last cycle still owns a FIFO slot even though its data hasn't landed.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign room      = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_even    = 1'b0;
    rd_odd     = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (FrameReady) begin
          state_d = RD_EVEN;
          idx_d   = '0;
        end
      end
      RD_EVEN: begin
        if (room) begin
          rd_even = 1'b1;
          state_d = RD_ODD;
        end
      end
      RD_ODD: begin
        if (room) begin
          rd_odd = 1'b1;
          idx_d  = idx_q + ADDR_W'(1);
          if (idx_q == LAST_IDX) begin
            last_issue = 1'b1;
            state_d    = DRAIN;
          end else begin
            state_d = RD_EVEN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_even_d = rd_even ? idx_q : addr_even_q;
  assign addr_odd_d  = rd_odd  ? idx_q : addr_odd_q;

  always_ff @(posedge ClockFromADC) begin
    if (!Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_even_q <= '0;
      addr_odd_q  <= '0;
      inflight_q  <= 1'b0;
      sel_odd_q   <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_even_q <= addr_even_d;
      addr_odd_q  <= addr_odd_d;
      inflight_q  <= rd_even || rd_odd;
      sel_odd_q   <= rd_odd;
      last_q      <= last_issue;
    end
  end

  assign rd.RdEnEven   = rd_even;
  assign rd.RdAddrEven = addr_even_d;
  assign rd.RdEnOdd    = rd_odd;
  assign rd.RdAddrOdd  = addr_odd_d;

  assign fifo_wdat = {last_q, ob_to_tc(sel_odd_q ? rd.RdDataOdd : rd.RdDataEven)};
  assign fifo_pop  = rd.OutValid && rd.OutReady;
  assign fifo_push = inflight_q && (!fifo_full || fifo_pop);

  sync_fifo_sa #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ClockFromADC),
    .rst_ni  (Reset),
    .push_i  (fifo_push),
    .dat_i   (fifo_wdat),
    .pop_i   (fifo_pop),
    .dat_o   (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd.OutValid = !fifo_empty;
  assign rd.OutData  = fifo_head[DATA_W-1:0];
  assign rd.OutLast  = fifo_head[DATA_W] && !fifo_empty;

  assign Busy    = (state_q != IDLE);
  assign Overrun = FrameReady && Busy;

endmodule
